// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - pc_unit pipeline-side bundle (master = pipeline control, slave = pc_unit)
interface pc_unit_if #(
   parameter int ADDR_W = 64,
   parameter int CNT_W  = 32
);
   logic              stall;
   logic [3:0]        icode;
   logic [3:0]        ifun;
   logic              cnd;
   logic [ADDR_W-1:0] valc;
   logic [ADDR_W-1:0] valm;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] valp;
   logic [1:0]        stat;
   logic              taken;
   logic [CNT_W-1:0]  retired;

   modport master (
      output stall, icode, ifun, cnd, valc, valm,
      input  pc, valp, stat, taken, retired
   );

   modport slave (
      input  stall, icode, ifun, cnd, valc, valm,
      output pc, valp, stat, taken, retired
   );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - Y86-64 PC register with next-PC select, status FSM, retire counter; optional PC_BOUND_CHECK_EN
module pc_unit #(
   parameter int                ADDR_W       = 64,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   parameter int                CNT_W        = 32,
   parameter int                MEM_BYTES    = 8192
) (
   input  logic       clk,
   input  logic       rst,
   pc_unit_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_AOK = 2'd0,
      ST_HLT = 2'd1,
      ST_ADR = 2'd2,
      ST_INS = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              taken_q, taken_d;
   logic [CNT_W-1:0]  retired_q, retired_d;

   logic [3:0]        ilen;
   logic [ADDR_W-1:0] valp;
   logic              invalid;
   logic [ADDR_W-1:0] next_pc;
   logic              non_seq;
   logic              out_of_bounds;

   if (MEM_BYTES < 1) begin : g_bad_mem_bytes
      $error("pc_unit: MEM_BYTES must be positive");
   end

   // Instruction length from icode; undefined codes use 1 so valp stays pc + 1
   always_comb begin
      ilen = 4'd1;
      case (bus.icode)
         4'h0, 4'h1, 4'h9:        ilen = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB:  ilen = 4'd2;
         4'h3, 4'h4, 4'h5:        ilen = 4'd10;
         4'h7, 4'h8:              ilen = 4'd9;
         default:                 ilen = 4'd1;
      endcase
   end

   assign valp = pc_q + ADDR_W'(ilen);

   // Legal (icode, ifun) pairs; anything else sends the FSM to INS
   always_comb begin
      invalid = 1'b0;
      case (bus.icode)
         4'h2, 4'h7: invalid = (bus.ifun > 4'd6);
         4'h6:       invalid = (bus.ifun > 4'd3);
         4'h0, 4'h1, 4'h3, 4'h4, 4'h5,
         4'h8, 4'h9, 4'hA, 4'hB:
                     invalid = (bus.ifun != 4'd0);
         default:    invalid = 1'b1;
      endcase
   end

   // Next-PC select; unconditional jmp (ifun 0) ignores cnd, halt keeps pc
   always_comb begin
      next_pc = valp;
      non_seq = 1'b0;
      case (bus.icode)
         4'h0: next_pc = pc_q;
         4'h7: begin
            if (bus.cnd || (bus.ifun == 4'd0)) begin
               next_pc = bus.valc;
               non_seq = 1'b1;
            end
         end
         4'h8: begin
            next_pc = bus.valc;
            non_seq = 1'b1;
         end
         4'h9: begin
            next_pc = bus.valm;
            non_seq = 1'b1;
         end
         default: next_pc = valp;
      endcase
   end

`ifdef PC_BOUND_CHECK_EN
   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

   // Extra bit keeps pc + len from wrapping past the limit unnoticed
   assign out_of_bounds = ({1'b0, next_pc} >= MEM_LIMIT) ||
                          (({1'b0, pc_q} + (ADDR_W+1)'(ilen)) > MEM_LIMIT);
`else
   assign out_of_bounds = 1'b0;
`endif

   // Status FSM and datapath next-state; INS outranks ADR, faults are sticky
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      retired_d = retired_q;
      taken_d   = 1'b0;
      if ((state_q == ST_AOK) && !bus.stall) begin
         if (invalid) begin
            state_d = ST_INS;
         end else if (out_of_bounds) begin
            state_d = ST_ADR;
         end else if (bus.icode == 4'h0) begin
            state_d   = ST_HLT;
            retired_d = retired_q + 1'b1;
         end else begin
            pc_d      = next_pc;
            retired_d = retired_q + 1'b1;
            taken_d   = non_seq;
         end
      end
   end

   // State registers with asynchronous reset to the reset vector
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_AOK;
         pc_q      <= RESET_VECTOR;
         taken_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         taken_q   <= taken_d;
         retired_q <= retired_d;
      end
   end

   assign bus.pc      = pc_q;
   assign bus.valp    = valp;
   assign bus.stat    = state_q;
   assign bus.taken   = taken_q;
   assign bus.retired = retired_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit against a behavioural model
module tb_pc_unit;
   localparam int          ADDR_W = 64;
   localparam int          CNT_W  = 32;
   localparam logic [63:0] RV     = 64'h0;
   localparam int          MEMB   = 'h1000;

   logic clk;
   logic rst;

   pc_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   pc_unit #(
      .ADDR_W(ADDR_W), .RESET_VECTOR(RV), .CNT_W(CNT_W), .MEM_BYTES(MEMB)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] m_pc;
   logic [1:0]  m_stat;
   logic        m_taken;
   logic [31:0] m_ret;

   function automatic logic [3:0] len_of(input logic [3:0] ic);
      if (ic == 4'h3 || ic == 4'h4 || ic == 4'h5) return 4'd10;
      if (ic == 4'h7 || ic == 4'h8) return 4'd9;
      if (ic == 4'h2 || ic == 4'h6 || ic == 4'hA || ic == 4'hB) return 4'd2;
      return 4'd1;
   endfunction

   function automatic bit is_valid(input logic [3:0] ic, input logic [3:0] fn);
      if (ic >= 4'hC) return 0;
      if (ic == 4'h2 || ic == 4'h7) return fn <= 4'd6;
      if (ic == 4'h6) return fn <= 4'd3;
      return fn == 4'd0;
   endfunction

   task automatic model_reset();
      m_pc = RV; m_stat = 2'd0; m_taken = 1'b0; m_ret = 32'd0;
   endtask

   task automatic model_edge(input logic st, input logic [3:0] ic, input logic [3:0] fn,
                             input logic c, input logic [63:0] vc, input logic [63:0] vm);
      logic [63:0] np;
      logic [64:0] endp;
      bit          jump;
      bit          oob;
      m_taken = 1'b0;
      if (m_stat != 2'd0 || st) return;
      if (!is_valid(ic, fn)) begin
         m_stat = 2'd3;
         return;
      end
      jump = 0;
      np   = m_pc + 64'(len_of(ic));
      if (ic == 4'h0) np = m_pc;
      if (ic == 4'h7 && (c || fn == 4'd0)) begin np = vc; jump = 1; end
      if (ic == 4'h8) begin np = vc; jump = 1; end
      if (ic == 4'h9) begin np = vm; jump = 1; end
      endp = 65'(m_pc) + 65'(len_of(ic));
      oob  = 0;
`ifdef PC_BOUND_CHECK_EN
      oob = (65'(np) >= 65'(MEMB)) || (endp > 65'(MEMB));
`endif
      if (oob) begin
         m_stat = 2'd2;
      end else if (ic == 4'h0) begin
         m_stat = 2'd1;
         m_ret  = m_ret + 1;
      end else begin
         m_pc    = np;
         m_ret   = m_ret + 1;
         m_taken = jump;
      end
   endtask

   task automatic apply(input logic st, input logic [3:0] ic, input logic [3:0] fn,
                        input logic c, input logic [63:0] vc, input logic [63:0] vm);
      bus.stall = st; bus.icode = ic; bus.ifun = fn;
      bus.cnd = c; bus.valc = vc; bus.valm = vm;
      @(posedge clk);
      model_edge(st, ic, fn, c, vc, vm);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      model_reset();
      n_cmp++; if (bus.pc !== RV) begin n_bad++; $display("FAIL reset_pc: got %0h expected %0h", bus.pc, RV); end
      n_cmp++; if (bus.stat !== 2'd0) begin n_bad++; $display("FAIL reset_stat: got %0d expected 0", bus.stat); end
      n_cmp++; if (bus.taken !== 1'b0) begin n_bad++; $display("FAIL reset_taken: got %0b expected 0", bus.taken); end
      n_cmp++; if (bus.retired !== 32'd0) begin n_bad++; $display("FAIL reset_retired: got %0d expected 0", bus.retired); end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_sequential();
      logic [63:0] exp_pc [3];
      logic [3:0]  ics [3];
      exp_pc = '{64'd1, 64'd11, 64'd13};
      ics    = '{4'h1, 4'h3, 4'h6};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, ics[i], 4'h0, 1'b0, 64'h0, 64'h0);
         n_cmp++; if (bus.pc !== exp_pc[i]) begin n_bad++; $display("FAIL seq_pc%0d: got %0h expected %0h", i, bus.pc, exp_pc[i]); end
      end
      n_cmp++; if (bus.retired !== 32'd3) begin n_bad++; $display("FAIL seq_retired: got %0d expected 3", bus.retired); end
      n_cmp++; if (bus.stat !== 2'd0) begin n_bad++; $display("FAIL seq_stat: got %0d expected 0", bus.stat); end
   endtask

   task automatic test_jumps();
      do_reset();
      apply(1'b0, 4'h7, 4'h0, 1'b0, 64'h20, 64'h0);
      n_cmp++; if (bus.pc !== 64'h20 || bus.taken !== 1'b1) begin n_bad++; $display("FAIL jmp_uncond: got pc %0h taken %0b expected 20 1", bus.pc, bus.taken); end
      apply(1'b0, 4'h7, 4'h1, 1'b0, 64'h100, 64'h0);
      n_cmp++; if (bus.pc !== 64'h29 || bus.taken !== 1'b0) begin n_bad++; $display("FAIL jxx_not_taken: got pc %0h taken %0b expected 29 0", bus.pc, bus.taken); end
      apply(1'b0, 4'h7, 4'h1, 1'b1, 64'h100, 64'h0);
      n_cmp++; if (bus.pc !== 64'h100 || bus.taken !== 1'b1) begin n_bad++; $display("FAIL jxx_taken: got pc %0h taken %0b expected 100 1", bus.pc, bus.taken); end
      apply(1'b0, 4'h1, 4'h0, 1'b0, 64'h0, 64'h0);
      n_cmp++; if (bus.pc !== 64'h101 || bus.taken !== 1'b0) begin n_bad++; $display("FAIL jxx_taken_drop: got pc %0h taken %0b expected 101 0", bus.pc, bus.taken); end
   endtask

   task automatic test_call_ret();
      apply(1'b0, 4'h8, 4'h0, 1'b0, 64'h400, 64'h0);
      n_cmp++; if (bus.pc !== 64'h400 || bus.taken !== 1'b1) begin n_bad++; $display("FAIL call: got pc %0h taken %0b expected 400 1", bus.pc, bus.taken); end
      apply(1'b0, 4'h9, 4'h0, 1'b0, 64'h0, 64'h35);
      n_cmp++; if (bus.pc !== 64'h35 || bus.taken !== 1'b1) begin n_bad++; $display("FAIL ret: got pc %0h taken %0b expected 35 1", bus.pc, bus.taken); end
      n_cmp++; if (bus.retired !== m_ret) begin n_bad++; $display("FAIL call_ret_retired: got %0d expected %0d", bus.retired, m_ret); end
   endtask

   task automatic test_stall();
      logic [63:0] pc0;
      logic [31:0] r0;
      pc0 = m_pc;
      r0  = m_ret;
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 4'h6, 4'h0, 1'b0, 64'h0, 64'h0);
         n_cmp++; if (bus.pc !== pc0 || bus.retired !== r0 || bus.taken !== 1'b0) begin
            n_bad++; $display("FAIL stall_hold%0d: got pc %0h ret %0d taken %0b expected %0h %0d 0", i, bus.pc, bus.retired, bus.taken, pc0, r0);
         end
      end
      apply(1'b0, 4'h6, 4'h0, 1'b0, 64'h0, 64'h0);
      n_cmp++; if (bus.pc !== pc0 + 64'd2) begin n_bad++; $display("FAIL stall_release: got %0h expected %0h", bus.pc, pc0 + 64'd2); end
   endtask

   task automatic test_invalid_and_reset();
      logic [63:0] pc0;
      pc0 = m_pc;
      apply(1'b0, 4'hE, 4'h0, 1'b0, 64'h0, 64'h0);
      n_cmp++; if (bus.stat !== 2'd3 || bus.pc !== pc0) begin n_bad++; $display("FAIL ins_enter: got stat %0d pc %0h expected 3 %0h", bus.stat, bus.pc, pc0); end
      apply(1'b0, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0);
      apply(1'b0, 4'h7, 4'h0, 1'b1, 64'h500, 64'h0);
      n_cmp++; if (bus.stat !== 2'd3 || bus.pc !== pc0 || bus.taken !== 1'b0) begin
         n_bad++; $display("FAIL ins_sticky: got stat %0d pc %0h taken %0b expected 3 %0h 0", bus.stat, bus.pc, bus.taken, pc0);
      end
      #3 rst = 1'b1;
      #1;
      model_reset();
      n_cmp++; if (bus.pc !== RV || bus.stat !== 2'd0) begin n_bad++; $display("FAIL async_reset: got pc %0h stat %0d expected %0h 0", bus.pc, bus.stat, RV); end
      @(posedge clk);
      #1 rst = 1'b0;
      apply(1'b0, 4'h2, 4'h7, 1'b0, 64'h0, 64'h0);
      n_cmp++; if (bus.stat !== 2'd3) begin n_bad++; $display("FAIL ins_cmov_ifun: got %0d expected 3", bus.stat); end
      do_reset();
      apply(1'b0, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0);
      apply(1'b0, 4'h1, 4'h0, 1'b0, 64'h0, 64'h0);
      n_cmp++; if (bus.stat !== 2'd1 || bus.pc !== RV || bus.retired !== 32'd1) begin
         n_bad++; $display("FAIL halt: got stat %0d pc %0h ret %0d expected 1 %0h 1", bus.stat, bus.pc, bus.retired, RV);
      end
   endtask

   task automatic test_bounds();
      do_reset();
      apply(1'b0, 4'h7, 4'h0, 1'b0, 64'h2000, 64'h0);
`ifdef PC_BOUND_CHECK_EN
      n_cmp++; if (bus.stat !== 2'd2 || bus.pc !== RV) begin n_bad++; $display("FAIL bound_jmp: got stat %0d pc %0h expected 2 %0h", bus.stat, bus.pc, RV); end
`else
      n_cmp++; if (bus.stat !== 2'd0 || bus.pc !== 64'h2000) begin n_bad++; $display("FAIL bound_jmp: got stat %0d pc %0h expected 0 2000", bus.stat, bus.pc); end
`endif
      do_reset();
      apply(1'b0, 4'h7, 4'h0, 1'b0, 64'hFF8, 64'h0);
      apply(1'b0, 4'h3, 4'h0, 1'b0, 64'h0, 64'h0);
      n_cmp++; if (bus.stat !== m_stat || bus.pc !== m_pc) begin n_bad++; $display("FAIL bound_len: got stat %0d pc %0h expected %0d %0h", bus.stat, bus.pc, m_stat, m_pc); end
      do_reset();
      apply(1'b0, 4'h7, 4'h0, 1'b0, 64'hFFF, 64'h0);
      apply(1'b0, 4'h1, 4'h0, 1'b0, 64'h0, 64'h0);
      n_cmp++; if (bus.stat !== m_stat || bus.pc !== m_pc) begin n_bad++; $display("FAIL bound_edge: got stat %0d pc %0h expected %0d %0h", bus.stat, bus.pc, m_stat, m_pc); end
   endtask

   task automatic test_wrap();
      logic [63:0] exp_vp;
      do_reset();
      apply(1'b0, 4'h8, 4'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0);
      bus.icode = 4'h3; bus.ifun = 4'h0;
      #1;
      exp_vp = m_pc + 64'd10;
      n_cmp++; if (bus.valp !== exp_vp) begin n_bad++; $display("FAIL wrap_valp: got %0h expected %0h", bus.valp, exp_vp); end
      apply(1'b0, 4'h3, 4'h0, 1'b0, 64'h0, 64'h0);
      n_cmp++; if (bus.pc !== m_pc || bus.stat !== m_stat) begin n_bad++; $display("FAIL wrap_pc: got pc %0h stat %0d expected %0h %0d", bus.pc, bus.stat, m_pc, m_stat); end
   endtask

   task automatic test_random();
      logic [3:0]  ic, fn;
      logic        st, c;
      logic [63:0] vc, vm, exp_vp;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (m_stat != 2'd0 && $urandom_range(0, 3) == 0) do_reset();
         ic = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) fn = 4'($urandom_range(0, 15));
         else if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 6));
         else if (ic == 4'h6) fn = 4'($urandom_range(0, 3));
         else fn = 4'h0;
         if (ic >= 4'hC && $urandom_range(0, 1) == 0) ic = 4'h1;
         if (ic == 4'h0 && $urandom_range(0, 2) != 0) ic = 4'h6;
         st = ($urandom_range(0, 4) == 0);
         c  = 1'($urandom_range(0, 1));
         vc = ($urandom_range(0, 7) == 0) ? {32'($urandom), 32'($urandom)} : 64'($urandom_range(0, 'h1100));
         vm = 64'($urandom_range(0, 'h1100));
         bus.stall = st; bus.icode = ic; bus.ifun = fn;
         bus.cnd = c; bus.valc = vc; bus.valm = vm;
         #1;
         exp_vp = m_pc + 64'(len_of(ic));
         n_cmp++; if (bus.valp !== exp_vp) begin n_bad++; $display("FAIL rnd%0d_valp: got %0h expected %0h", i, bus.valp, exp_vp); end
         apply(st, ic, fn, c, vc, vm);
         n_cmp++; if (bus.pc !== m_pc) begin n_bad++; $display("FAIL rnd%0d_pc: got %0h expected %0h", i, bus.pc, m_pc); end
         n_cmp++; if (bus.stat !== m_stat) begin n_bad++; $display("FAIL rnd%0d_stat: got %0d expected %0d", i, bus.stat, m_stat); end
         n_cmp++; if (bus.taken !== m_taken) begin n_bad++; $display("FAIL rnd%0d_taken: got %0b expected %0b", i, bus.taken, m_taken); end
         n_cmp++; if (bus.retired !== m_ret) begin n_bad++; $display("FAIL rnd%0d_retired: got %0d expected %0d", i, bus.retired, m_ret); end
      end
   endtask

   initial begin
      rst = 1'b0;
      bus.stall = 1'b0; bus.icode = 4'h1; bus.ifun = 4'h0;
      bus.cnd = 1'b0; bus.valc = 64'h0; bus.valm = 64'h0;
      model_reset();
      test_reset();
      test_sequential();
      test_jumps();
      test_call_ret();
      test_stall();
      test_invalid_and_reset();
      test_bounds();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the single-cycle Y86-64 program-counter register.
- Holds the PC, computes valP from icode, and selects the next PC on each accepted cycle (sequential, taken jump, call, ret).
- Adds reset, a stall handshake, instruction validity checking, a sticky status FSM (AOK/HLT/ADR/INS) and a retired-instruction counter.
- Sits between the fetch/decode stages (drives pc to instruction memory) and the execute/memory stages (consumes cnd, valC, valM).

Parameters:
- ADDR_W, 64, width of the PC, valC, valM and valP.
- RESET_VECTOR, 0, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.
- MEM_BYTES, 8192, instruction memory size in bytes; used only with PC_BOUND_CHECK_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  1 = hold all state this cycle.
- icode  in  4  current instruction code.
- ifun  in  4  current function code.
- cnd  in  1  condition result for jXX (and cmovXX, which is ignored here).
- valc  in  ADDR_W  constant / destination field.
- valm  in  ADDR_W  memory read value (return address for ret).
- pc  out  ADDR_W  current PC, registered.
- valp  out  ADDR_W  pc + instruction length, combinational.
- stat  out  2  status: 0 AOK, 1 HLT, 2 ADR, 3 INS; registered.
- taken  out  1  registered; 1 for the cycle after a non-sequential PC load.
- retired  out  CNT_W  count of accepted instructions; registered.

Behaviour:
- Reset (asynchronous, may arrive mid-operation):
  - pc = RESET_VECTOR, stat = AOK, taken = 0, retired = 0.
  - Takes effect immediately, regardless of stall or current state.
- Instruction length, by icode (used for valp):
  - 0, 1, 9: 1 byte.
  - 2, 6, A, B: 2 bytes.
  - 3, 4, 5: 10 bytes.
  - 7, 8: 9 bytes.
  - C-F: valp = pc + 1 (value unused).
- Arithmetic: all PC arithmetic is unsigned modulo 2^ADDR_W. pc + len wraps silently when the check is off.
- Validity: an instruction is invalid, and the next state is INS, when any of these hold:
  - icode is C-F;
  - icode 2 or 7 with ifun > 6;
  - icode 6 with ifun > 3;
  - icode 0, 1, 3, 4, 5, 8, 9, A or B with ifun != 0.
- FSM states: AOK, HLT, ADR, INS. HLT, ADR and INS are sticky until rst.
- In AOK with stall = 1:
  - pc, stat and retired hold.
  - taken is driven to 0.
- In AOK with stall = 0, per edge:
  - invalid instruction: stat <= INS, pc holds, retired holds, taken <= 0.
  - icode 0 (halt): stat <= HLT, pc holds, retired += 1, taken <= 0.
  - icode 7 (jmp/jXX): cnd = 1 -> pc <= valc, taken <= 1. cnd = 0 -> pc <= valp, taken <= 0. ifun 0 (jmp) always uses valc regardless of cnd.
  - icode 8 (call): pc <= valc, taken <= 1.
  - icode 9 (ret): pc <= valm, taken <= 1.
  - all other valid icodes: pc <= valp, taken <= 0.
  - retired += 1 for every valid instruction. The counter wraps at 2^CNT_W.
- In HLT/ADR/INS: pc, retired and stat are frozen, taken = 0, stall is ignored.
- Latency: the next PC is visible on pc one clock after the accepting edge. valp follows pc and icode combinationally.

Optional Feature:
- Macro: PC_BOUND_CHECK_EN.
- When defined:
  - If the selected next PC is >= MEM_BYTES, or pc + len > MEM_BYTES for the current instruction, then on the accepting edge stat <= ADR, pc holds, retired holds, taken <= 0.
  - INS takes priority over ADR.
- When undefined: no bounds logic is synthesised, stat never reaches ADR, and MEM_BYTES is unused.

Test Plan:
- Reset then stream nop(1,0), irmovq(3,0), addq(6,0) with stall = 0 -> pc = 0, 1, 11, 13; retired = 3; stat = AOK.
- At pc = 0x20: jXX (7,1) with cnd = 0, valc = 0x100 -> pc = 0x29, taken = 0. Repeat with cnd = 1 -> pc = 0x100, taken = 1 for one cycle.
- call (8,0) with valc = 0x400, then ret (9,0) with valm = 0x35 -> pc = 0x400, then 0x35.
- stall = 1 for 3 cycles during addq -> pc and retired unchanged. Release stall -> pc advances by 2.
- icode = 0xE -> stat = INS, pc frozen. Following halt/jmp inputs have no effect. Assert rst mid-cycle -> pc = RESET_VECTOR and stat = AOK immediately.
- With PC_BOUND_CHECK_EN, MEM_BYTES = 0x100: jmp to 0x200 -> stat = ADR, pc unchanged. Without the macro, the same stimulus gives pc = 0x200.
